// File: rtl/tmds_pkg.sv
// Shared types, control tokens and helpers for the DVI TMDS encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tmds_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] disp_t;

  // Control tokens indexed by {C1,C0}; bit 0 is the first bit on the wire.
  localparam tmds_sym_t TOK_CTL00 = 10'h354;
  localparam tmds_sym_t TOK_CTL01 = 10'h0AB;
  localparam tmds_sym_t TOK_CTL10 = 10'h154;
  localparam tmds_sym_t TOK_CTL11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-in / symbol-out bundle between the framestore and the TMDS encoder.
// Latency: n/a (wires only).
// Backpressure: none; the pixel stream is free-running on the pixel clock.
interface tmds_encoder_if;
  import tmds_pkg::*;

  logic [7:0] red_i;
  logic [7:0] green_i;
  logic [7:0] blue_i;
  logic       hsync_i;
  logic       vsync_i;
  logic       de_i;
  logic       pat_sel_i;
  tmds_sym_t  tmds0_o;
  tmds_sym_t  tmds1_o;
  tmds_sym_t  tmds2_o;

  // Encoder side.
  modport slave (
    input  red_i, green_i, blue_i, hsync_i, vsync_i, de_i, pat_sel_i,
    output tmds0_o, tmds1_o, tmds2_o
  );

  // Pixel source / serialiser side.
  modport master (
    output red_i, green_i, blue_i, hsync_i, vsync_i, de_i, pat_sel_i,
    input  tmds0_o, tmds1_o, tmds2_o
  );

endinterface

// File: rtl/tmds_chan.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage with running disparity.
// Latency: 2 clk cycles from d/c0/c1/de to sym.
// Backpressure: none; a new symbol is produced every cycle.
module tmds_chan
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output tmds_sym_t  sym
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm_next;

  logic [8:0] q_m;
  logic       de_q;
  logic       c0_q;
  logic       c1_q;

  logic [3:0] n1q;
  disp_t      diff;
  disp_t      qm8_x2;
  disp_t      nqm8_x2;
  disp_t      cnt;
  disp_t      cnt_next;
  tmds_sym_t  sym_next;

  assign n1 = popcount8(d);

  // Stage 1: choose XOR or XNOR chain to minimise transitions.
  always_comb begin
    use_xnor   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    qm_next    = '0;
    qm_next[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ d[i]) : (qm_next[i-1] ^ d[i]);
    end
    qm_next[8] = ~use_xnor;
  end

  // Stage 1 register: q_m word plus the control bits travelling alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_m  <= '0;
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      q_m  <= qm_next;
      de_q <= de;
      c0_q <= c0;
      c1_q <= c1;
    end
  end

  // diff = ones - zeros of q_m[7:0]; 2*n1q wraps harmlessly in 5 bits when n1q is 8.
  assign n1q     = popcount8(q_m[7:0]);
  assign diff    = disp_t'({n1q, 1'b0} - 5'd8);
  assign qm8_x2  = q_m[8] ? 5'sd2 : 5'sd0;
  assign nqm8_x2 = q_m[8] ? 5'sd0 : 5'sd2;

  // Stage 2: token during blanking, otherwise pick inversion to steer disparity toward zero.
  always_comb begin
    sym_next = TOK_CTL00;
    cnt_next = cnt;
    if (!de_q) begin
      unique case ({c1_q, c0_q})
        2'b00:   sym_next = TOK_CTL00;
        2'b01:   sym_next = TOK_CTL01;
        2'b10:   sym_next = TOK_CTL10;
        default: sym_next = TOK_CTL11;
      endcase
      cnt_next = '0;
    end else if ((cnt == 5'sd0) || (n1q == 4'd4)) begin
      sym_next = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_next = q_m[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (n1q > 4'd4)) || ((cnt < 5'sd0) && (n1q < 4'd4))) begin
      sym_next = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_next = cnt + qm8_x2 - diff;
    end else begin
      sym_next = {1'b0, q_m[8], q_m[7:0]};
      cnt_next = cnt + diff - nqm8_x2;
    end
  end

  // Stage 2 register: output symbol and running disparity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym <= TOK_CTL00;
      cnt <= '0;
    end else begin
      sym <= sym_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: RGB + syncs + de to three 10-bit symbol streams (ch0 blue, ch1 green, ch2 red); TMDS_PATTERN_EN adds a colour-bar generator.
// Latency: 2 clk_i cycles, all channels aligned.
// Backpressure: none; consumes and produces one pixel every cycle.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tmds_encoder_if.slave bus
);

  logic       hs_c;
  logic       vs_c;
  logic [7:0] r_s;
  logic [7:0] g_s;
  logic [7:0] b_s;

  // C0/C1 are 1 while the corresponding sync is active, whatever the source polarity.
  assign hs_c = bus.hsync_i ^ ~HSYNC_POL;
  assign vs_c = bus.vsync_i ^ ~VSYNC_POL;

`ifdef TMDS_PATTERN_EN
  logic [11:0] pix_cnt;
  logic [2:0]  bar;

  // Pixel position within the active line; restarts at every blanking cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_cnt <= '0;
    end else begin
      pix_cnt <= bus.de_i ? (pix_cnt + 12'd1) : 12'd0;
    end
  end

  assign bar = pix_cnt[9:7];

  // Eight 128-pixel bars replace the live pixel when the pattern is selected.
  always_comb begin
    r_s = bus.red_i;
    g_s = bus.green_i;
    b_s = bus.blue_i;
    if (bus.pat_sel_i) begin
      r_s = {8{bar[2]}};
      g_s = {8{bar[1]}};
      b_s = {8{bar[0]}};
    end
  end
`else
  logic unused_pat_sel;

  assign unused_pat_sel = bus.pat_sel_i;
  assign r_s = bus.red_i;
  assign g_s = bus.green_i;
  assign b_s = bus.blue_i;
`endif

  tmds_chan u_ch0 (
    .clk (clk_i),
    .rst (rst_i),
    .d   (b_s),
    .c0  (hs_c),
    .c1  (vs_c),
    .de  (bus.de_i),
    .sym (bus.tmds0_o)
  );

  tmds_chan u_ch1 (
    .clk (clk_i),
    .rst (rst_i),
    .d   (g_s),
    .c0  (1'b0),
    .c1  (1'b0),
    .de  (bus.de_i),
    .sym (bus.tmds1_o)
  );

  tmds_chan u_ch2 (
    .clk (clk_i),
    .rst (rst_i),
    .d   (r_s),
    .c0  (1'b0),
    .c1  (1'b0),
    .de  (bus.de_i),
    .sym (bus.tmds2_o)
  );

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: scoreboard of expected pixels/tokens, checked through a reference TMDS decoder.
// Latency: expects symbols 2 clocks after the pixel is driven.
// Backpressure: n/a.
module tb_tmds_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tmds_encoder_if vif ();

  tmds_encoder dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (vif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] xr;
    logic [7:0] xg;
    logic [7:0] xb;
    logic       has_sym;
    logic [9:0] sym0;
    logic       has_rd;
    int         rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd0 = 0, rd1 = 0, rd2 = 0;
  int   tb_pix = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] tok(input logic c1, input logic c0);
    logic [9:0] t;
    case ({c1, c0})
      2'b00:   t = 10'h354;
      2'b01:   t = 10'h0AB;
      2'b10:   t = 10'h154;
      default: t = 10'h2AB;
    endcase
    return t;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] d;
    logic [7:0] o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  function automatic int sym_disp(input logic [9:0] s);
    return 2 * $countones(s) - 10;
  endfunction

  function automatic logic in_bound(input int v);
    return (v <= 10) && (v >= -10);
  endfunction

  task automatic compare(input exp_t x);
    if (!x.de) begin
      check_eq("tok0", 32'(vif.tmds0_o), 32'(tok(x.vs, x.hs)));
      check_eq("tok1", 32'(vif.tmds1_o), 32'h354);
      check_eq("tok2", 32'(vif.tmds2_o), 32'h354);
      rd0 = 0; rd1 = 0; rd2 = 0;
    end else begin
      check_eq("dec_b", 32'(tmds_dec(vif.tmds0_o)), 32'(x.xb));
      check_eq("dec_g", 32'(tmds_dec(vif.tmds1_o)), 32'(x.xg));
      check_eq("dec_r", 32'(tmds_dec(vif.tmds2_o)), 32'(x.xr));
      rd0 += sym_disp(vif.tmds0_o);
      rd1 += sym_disp(vif.tmds1_o);
      rd2 += sym_disp(vif.tmds2_o);
      check_eq("rd_bound", 32'(in_bound(rd0) && in_bound(rd1) && in_bound(rd2)), 32'd1);
    end
    if (x.has_sym) check_eq("sym0", 32'(vif.tmds0_o), 32'(x.sym0));
    if (x.has_rd)  check_eq("rd0", 32'(rd0), 32'(x.rd));
  endtask

  // Drive one pixel, push its expectation, advance a clock and retire the entry now at the output.
  task automatic step(input logic de, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic hs, input logic vs, input logic ps,
                      input logic has_sym, input logic [9:0] s0, input logic has_rd, input int rdv);
    exp_t e;
    logic [11:0] pix;
    logic [2:0]  bar;
    pix = 12'(tb_pix);
    bar = pix[9:7];
    vif.de_i = de; vif.red_i = r; vif.green_i = g; vif.blue_i = b;
    vif.hsync_i = hs; vif.vsync_i = vs; vif.pat_sel_i = ps;
    e.de = de; e.hs = hs; e.vs = vs;
    e.xr = r; e.xg = g; e.xb = b;
`ifdef TMDS_PATTERN_EN
    if (ps) begin
      e.xr = bar[2] ? 8'hFF : 8'h00;
      e.xg = bar[1] ? 8'hFF : 8'h00;
      e.xb = bar[0] ? 8'hFF : 8'h00;
    end
`endif
    e.has_sym = has_sym; e.sym0 = s0; e.has_rd = has_rd; e.rd = rdv;
    sb.push_back(e);
    tb_pix = de ? tb_pix + 1 : 0;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) compare(sb.pop_front());
  endtask

  task automatic idle(input logic hs, input logic vs);
    step(1'b0, 8'h00, 8'h00, 8'h00, hs, vs, 1'b0, 1'b0, 10'h0, 1'b0, 0);
  endtask

  task automatic blue(input logic [7:0] b, input logic [9:0] s0, input int rdv);
    step(1'b1, 8'h5A, 8'hC3, b, 1'b0, 1'b0, 1'b0, 1'b1, s0, 1'b1, rdv);
  endtask

  initial begin
    vif.de_i = 0; vif.red_i = 0; vif.green_i = 0; vif.blue_i = 0;
    vif.hsync_i = 0; vif.vsync_i = 0; vif.pat_sel_i = 0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_t0", 32'(vif.tmds0_o), 32'h354);
    check_eq("rst_t1", 32'(vif.tmds1_o), 32'h354);
    check_eq("rst_t2", 32'(vif.tmds2_o), 32'h354);
    rst = 1'b0;

    // Control tokens from syncs.
    idle(0, 0); idle(0, 0);
    idle(1, 0); idle(1, 0);
    idle(1, 1); idle(0, 1); idle(0, 0);

    // Fixed vectors with known symbols and running disparity.
    blue(8'h00, 10'h100, -8);
    blue(8'h00, 10'h3FF, 2);
    blue(8'h00, 10'h100, -6);
    idle(0, 0);
    blue(8'hFF, 10'h200, -8);
    idle(1, 0);
    blue(8'h00, 10'h100, -8);
    idle(0, 0);

    // Randomised pixels, syncs and blanking.
    for (int i = 0; i < 10000; i++) begin
      logic ps;
`ifdef TMDS_PATTERN_EN
      ps = 1'b0;
`else
      ps = 1'($urandom_range(0, 1));
`endif
      step(($urandom_range(0, 7) != 0), 8'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ps, 1'b0, 10'h0, 1'b0, 0);
    end

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b0, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_t0", 32'(vif.tmds0_o), 32'h354);
    check_eq("arst_t1", 32'(vif.tmds1_o), 32'h354);
    check_eq("arst_t2", 32'(vif.tmds2_o), 32'h354);
    sb.delete();
    rd0 = 0; rd1 = 0; rd2 = 0; tb_pix = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Encoding after release starts from zero disparity.
    blue(8'h00, 10'h100, -8);
    blue(8'h00, 10'h3FF, 2);
    idle(0, 0);

`ifdef TMDS_PATTERN_EN
    // Colour bars across 1024 active pixels.
    idle(0, 0);
    for (int i = 0; i < 1024; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, 1'b0, 0);
    end
    idle(0, 0);
`endif

    idle(0, 0); idle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Downstream neighbour of the text/graphics framestore.
- Consumes its per-pixel red/green/blue bytes plus hsyn, vsyn and a data-enable, all on the pixel clock.
- Produces three DVI TMDS 10-bit symbol streams (blue=ch0, green=ch1, red=ch2) for the off-block 10:1 serialiser.
- Pure pixel-domain pipeline: per-channel DC-balance state, fixed latency, no back-pressure.

Parameters:
- HSYNC_POL, 1'b1: polarity of hsync_i; input is XORed with ~HSYNC_POL so the encoded C0 is 1 during sync.
- VSYNC_POL, 1'b1: same rule for vsync_i and C1.

Ports:
- clk_i  input  1  pixel clock (framestore pxl_clk).
- rst_i  input  1  asynchronous, active-high reset.
- red_i  input  8  red pixel byte.
- green_i  input  8  green pixel byte.
- blue_i  input  8  blue pixel byte.
- hsync_i  input  1  horizontal sync from framestore.
- vsync_i  input  1  vertical sync from framestore.
- de_i  input  1  active-video enable.
- pat_sel_i  input  1  test-pattern select; used only under TMDS_PATTERN_EN, otherwise ignored.
- tmds0_o  output  10  blue-channel symbol; bit 0 is transmitted first.
- tmds1_o  output  10  green-channel symbol.
- tmds2_o  output  10  red-channel symbol.

Behaviour:
- One clock (clk_i). Reset is asynchronous, active-high (rst_i). All flops reset on rst_i assertion, independent of clk_i.
- Reset values: all tmdsN_o = 10'h354 (control token C1C0=00); all disparity counters = 0; pipeline de = 0.
- Control inputs per channel: ch0 C0/C1 = polarity-corrected hsync/vsync; ch1 and ch2 C0/C1 = 0.
- Latency: exactly 2 clk_i cycles, input to symbol. All channels and de are aligned.
- Stage 1 (register q_m[8:0], de, C1/C0):
  - n1 = popcount(d).
  - If n1>4, or n1==4 with d[0]==0: XNOR chain, q_m[i] = q_m[i-1] ~^ d[i], q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - In both cases q_m[0]=d[0].
- Stage 2: n1q = popcount(q_m[7:0]), n0q = 8-n1q. cnt is 5-bit signed two's complement.
  - de=0: emit token by C1C0: 00→10'h354, 01→10'h0AB, 10→10'h154, 11→10'h2AB. cnt<=0.
  - de=1, cnt==0 or n1q==n0q: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
  - de=1, (cnt>0 & n1q>n0q) or (cnt<0 & n0q>n1q): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (n0q-n1q).
  - Otherwise: out = {0, q_m[8], q_m[7:0]}. cnt += (n1q-n0q) - 2*~q_m[8].
- Boundaries:
  - de falling edge: token is emitted on the very next stage-2 cycle and cnt clears.
  - de rising edge: encoding starts from cnt=0.
  - Reset mid-line: symbols immediately revert to 10'h354.
  - hsync/vsync are sampled every cycle regardless of de; only encoded while de=0.

Optional Feature:
- Macro: TMDS_PATTERN_EN.
- Defined:
  - Adds a 12-bit pixel counter; clears when de_i=0, increments while de_i=1.
  - When pat_sel_i=1, the stage-1 RGB is replaced by 8 vertical colour bars of 128 pixels each: bar index = counter[9:7], R=idx[2]?FF:00, G=idx[1]?FF:00, B=idx[0]?FF:00.
  - Syncs/de pass through unchanged; latency unchanged.
- Undefined: pat_sel_i is ignored; no counter is synthesised.

Decomposition:
- Package tmds_pkg:
  - tmds_sym_t (logic [9:0]).
  - disp_t (logic signed [4:0]).
  - Constants TOK_CTL00/01/10/11.
  - Function popcount8.
- Sub-module tmds_chan: one channel's two-stage encoder plus disparity counter. Inputs d[7:0], c0, c1, de; output sym. Instantiated 3×.
- Top level holds sync-polarity correction and the pattern generator.

Test Plan:
- Assert rst_i asynchronously mid-frame → all tmdsN_o = 10'h354 within the same cycle, without waiting for a clock edge. cnt=0 after release.
- de=0, hsync=1, vsync=0 (POL=1) → after 2 clocks tmds0=10'h0AB, tmds1=tmds2=10'h354. vsync=1, hsync=1 → tmds0=10'h2AB.
- de=1, blue=8'h00 for 3 cycles from cnt=0 → tmds0 = 10'h100, 10'h3FF, 10'h100. Internal cnt -8, +2, -6.
- de=1, blue=8'hFF from cnt=0 → tmds0=10'h200, cnt=-8. Then de=0 → token, cnt=0.
- Randomised RGB/de for 10k cycles through a reference TMDS decoder → decoded bytes equal inputs delayed 2 cycles; running disparity stays within ±10.
- TMDS_PATTERN_EN, pat_sel_i=1, de high for 1024 pixels → decoded pixel 0 = 000000, pixel 128 = 0000FF, pixel 896 = FFFFFF.
